vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, the single clock for the block.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port ce, input, 1, pixel-advance enable.
REQ-012 SHALL have port hpos, output, 10, current pixel column.
REQ-013 SHALL have port vpos, output, 10, current line.
REQ-014 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-015 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-016 SHALL have port display_on, output, 1, high inside the visible region.
REQ-017 SHALL have port line_start, output, 1, one-clk pulse on entry to hpos 0.
REQ-018 SHALL have port frame_start, output, 1, one-clk pulse on entry to (0,0).
REQ-019 SHALL have port frame_cnt, output, 8, count of completed frames.

Function
REQ-020 SHALL drive all outputs from flops; no output is a combinational function of inputs.
REQ-021 SHALL define H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (default 525).
REQ-022 SHALL leave every output unchanged on any clk edge where ce=0, except line_start and frame_start, which SHALL be 0.
REQ-023 SHALL, on each clk edge with ce=1, increment hpos, wrapping from H_TOTAL-1 to 0.
REQ-024 SHALL increment vpos only on the edge where hpos wraps, wrapping from V_TOTAL-1 to 0.
REQ-025 SHALL increment frame_cnt (mod 256, 255->0) on the edge where both hpos and vpos wrap.
REQ-026 SHALL align hsync, vsync and display_on with the hpos/vpos values presented on the same cycle, with zero cycles of lag.
REQ-027 SHALL drive hsync=0 iff H_VIS+H_FP <= hpos <= H_VIS+H_FP+H_SYNC-1 (default 656..751).
REQ-028 SHALL drive vsync=0 iff V_VIS+V_FP <= vpos <= V_VIS+V_FP+V_SYNC-1 (default 490..491).
REQ-029 SHALL drive display_on=1 iff hpos < H_VIS and vpos < V_VIS.
REQ-030 SHALL assert line_start for exactly one clk cycle, the cycle in which hpos first shows 0 after a ce=1 wrap.
REQ-031 SHALL assert frame_start for exactly one clk cycle, the cycle in which (hpos,vpos) first shows (0,0) after a ce=1 wrap; line_start SHALL also be high on that cycle.
REQ-032 SHALL never let hpos reach H_TOTAL or vpos reach V_TOTAL.

Reset
REQ-033 SHALL, on rst_n=0, immediately and without waiting for a clock edge set hpos=0, vpos=0, frame_cnt=0, hsync=1, vsync=1, display_on=1, line_start=0, frame_start=0.
REQ-034 SHALL, when reset is asserted mid-frame, abandon the frame and restart at (0,0) after release, with no pulse on line_start or frame_start.
REQ-035 SHALL, on the first ce=1 edge after reset release, present hpos=1, vpos=0.

Structure
REQ-036 SHALL take default timing constants from the shared package demoscene_pkg, which also holds the 10-bit position width constant.
REQ-037 SHALL implement horizontal and vertical counting with two instances of sub-module vga_axis_counter; each instance SHALL provide a wrapping counter plus a registered sync/visible decode.

Verification
REQ-038 The bench SHALL apply reset, hold ce=1, and run 800 clk -> hpos sequence 0..799,0; vpos=1; line_start high exactly once.
REQ-039 The bench SHALL run ce=1 from reset -> hsync low for exactly hpos 656..751 each line; vsync low for exactly lines 490..491 (1600 clk).
REQ-040 The bench SHALL run a full frame of 420000 clk -> frame_cnt=1, frame_start pulses once at (0,0), and display_on is high for exactly 307200 cycles.
REQ-041 The bench SHALL toggle ce 1/0 alternately -> positions advance every 2 clk, and pulses stay 1 clk wide.
REQ-042 The bench SHALL assert rst_n low at hpos=400, vpos=300 -> outputs take reset values immediately, and counting resumes from (0,0) with no pulse.
REQ-043 The bench SHALL run 256 frames -> frame_cnt wraps 255->0 on the 256th frame_start.

Source files
------------

// File: rtl/demoscene_pkg.sv
// Shared constants for the demoscene video blocks: position width and
// default 640x480@60 VGA timing, plus a helper to size a scan axis.
package demoscene_pkg;

   localparam int unsigned POS_W = 10;

   localparam int unsigned DEF_H_VIS  = 640;
   localparam int unsigned DEF_H_FP   = 16;
   localparam int unsigned DEF_H_SYNC = 96;
   localparam int unsigned DEF_H_BP   = 48;

   localparam int unsigned DEF_V_VIS  = 480;
   localparam int unsigned DEF_V_FP   = 10;
   localparam int unsigned DEF_V_SYNC = 2;
   localparam int unsigned DEF_V_BP   = 33;

   // Total period of one scan axis (visible + porches + sync)
   function automatic int unsigned axis_total(input int unsigned vis,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return vis + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping position counter with registered sync and
// visible flags. Flags are decoded from the next position so they line up
// with the position flop on the same cycle.
module vga_axis_counter
   import demoscene_pkg::*;
#(
   parameter int unsigned VIS  = DEF_H_VIS,
   parameter int unsigned FP   = DEF_H_FP,
   parameter int unsigned SYNC = DEF_H_SYNC,
   parameter int unsigned BP   = DEF_H_BP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [POS_W-1:0] pos,
   output logic             last,
   output logic             sync_n,
   output logic             vis
);

   localparam int unsigned      TOTAL      = axis_total(VIS, FP, SYNC, BP);
   localparam logic [POS_W-1:0] LAST_POS   = POS_W'(TOTAL - 1);
   localparam logic [POS_W-1:0] SYNC_FIRST = POS_W'(VIS + FP);
   localparam logic [POS_W-1:0] SYNC_LAST  = POS_W'(VIS + FP + SYNC - 1);
   localparam logic [POS_W-1:0] VIS_LIM    = POS_W'(VIS);

   logic [POS_W-1:0] pos_q, pos_d;
   logic             sync_n_q, sync_n_d;
   logic             vis_q, vis_d;

   assign last = (pos_q == LAST_POS);

   // Next position and its decode; holds everything when not enabled
   always_comb begin
      pos_d = pos_q;
      if (en) begin
         pos_d = last ? '0 : pos_q + 1'b1;
      end
      sync_n_d = !((pos_d >= SYNC_FIRST) && (pos_d <= SYNC_LAST));
      vis_d    = (pos_d < VIS_LIM);
   end

   // State flops; reset lands on position 0 (visible, sync inactive)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q    <= '0;
         sync_n_q <= 1'b1;
         vis_q    <= 1'b1;
      end else begin
         pos_q    <= pos_d;
         sync_n_q <= sync_n_d;
         vis_q    <= vis_d;
      end
   end

   assign pos    = pos_q;
   assign sync_n = sync_n_q;
   assign vis    = vis_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal and vertical axis counters, line/frame
// start strobes and a completed-frame counter, all advancing on ce.
module vga_timing_gen
   import demoscene_pkg::*;
#(
   parameter int unsigned H_VIS  = DEF_H_VIS,
   parameter int unsigned H_FP   = DEF_H_FP,
   parameter int unsigned H_SYNC = DEF_H_SYNC,
   parameter int unsigned H_BP   = DEF_H_BP,
   parameter int unsigned V_VIS  = DEF_V_VIS,
   parameter int unsigned V_FP   = DEF_V_FP,
   parameter int unsigned V_SYNC = DEF_V_SYNC,
   parameter int unsigned V_BP   = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             hsync,
   output logic             vsync,
   output logic             display_on,
   output logic             line_start,
   output logic             frame_start,
   output logic [7:0]       frame_cnt
);

   logic h_last, v_last;
   logic h_vis, v_vis;
   logic v_en;

   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;

   assign v_en = ce & h_last;

   vga_axis_counter #(
      .VIS  (H_VIS),
      .FP   (H_FP),
      .SYNC (H_SYNC),
      .BP   (H_BP)
   ) u_h (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (ce),
      .pos    (hpos),
      .last   (h_last),
      .sync_n (hsync),
      .vis    (h_vis)
   );

   vga_axis_counter #(
      .VIS  (V_VIS),
      .FP   (V_FP),
      .SYNC (V_SYNC),
      .BP   (V_BP)
   ) u_v (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (v_en),
      .pos    (vpos),
      .last   (v_last),
      .sync_n (vsync),
      .vis    (v_vis)
   );

   // Strobes fire on the edge that wraps into column 0 / origin
   always_comb begin
      line_start_d  = ce & h_last;
      frame_start_d = ce & h_last & v_last;
      frame_cnt_d   = frame_cnt_q;
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   // Strobe and frame counter flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   // Both visible flags are flops, so this stays aligned with hpos/vpos
   assign display_on  = h_vis & v_vis;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
